// File: rtl/dual_tap_ram_delay.sv
// rtl/dual_tap_ram_delay.sv - circular-RAM delay line with two registered read taps
// Each accepted sample is written once; taps A and B read it back DELAY_A_P / DELAY_B_P accepts later.
module dual_tap_ram_delay #(
    parameter int WIDTH_P   = 8,
    parameter int DELAY_P   = 12,
    parameter int DELAY_A_P = DELAY_P,
    parameter int DELAY_B_P = DELAY_P
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] data_a_o,
    output logic [WIDTH_P-1:0] data_b_o
);

    localparam int DEPTH = DELAY_P + 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] PTR_LAST = AW'(DELAY_P);
    localparam logic [AW-1:0] RA_INIT  = AW'(DELAY_P - DELAY_A_P);
    localparam logic [AW-1:0] RB_INIT  = AW'(DELAY_P - DELAY_B_P);

    if (DELAY_P < 1) begin : g_bad_depth
        $fatal(1, "dual_tap_ram_delay: DELAY_P must be >= 1");
    end
    if (DELAY_A_P < 0 || DELAY_A_P > DELAY_P) begin : g_bad_tap_a
        $fatal(1, "dual_tap_ram_delay: DELAY_A_P out of range 0..DELAY_P");
    end
    if (DELAY_B_P < 0 || DELAY_B_P > DELAY_P) begin : g_bad_tap_b
        $fatal(1, "dual_tap_ram_delay: DELAY_B_P out of range 0..DELAY_P");
    end

    logic [WIDTH_P-1:0] mem [DEPTH];
    logic [AW-1:0]      wr;
    logic [AW-1:0]      ra;
    logic [AW-1:0]      rb;
    logic               accept;

    // Pointers wrap at DELAY_P so the ring holds exactly DELAY_P+1 samples.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = ~valid_o | ready_i;
    assign accept  = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr] <= data_i;
        end
    end

    // A tap whose read address equals the write address is a zero-delay tap: forward data_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr       <= PTR_LAST;
            ra       <= RA_INIT;
            rb       <= RB_INIT;
            data_a_o <= '0;
            data_b_o <= '0;
        end else if (accept) begin
            wr       <= next_ptr(wr);
            ra       <= next_ptr(ra);
            rb       <= next_ptr(rb);
            data_a_o <= (ra == wr) ? data_i : mem[ra];
            data_b_o <= (rb == wr) ? data_i : mem[rb];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
        end else if (ready_o) begin
            valid_o <= valid_i;
        end
    end

endmodule

// File: tb/tb_dual_tap_ram_delay.sv
// tb/tb_dual_tap_ram_delay.sv - randomized and directed bench against a queue-based delay model
module tb_dual_tap_ram_delay;
    localparam int W = 8;
    localparam int D = 12;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         vin  = 1'b0;
    logic         rin  = 1'b0;
    logic [W-1:0] din  = '0;

    logic         rdy_x, vld_x, rdy_y, vld_y;
    logic [W-1:0] xa, xb, ya, yb;

    always #5 clk = ~clk;

    dual_tap_ram_delay #(.WIDTH_P(W), .DELAY_P(D), .DELAY_A_P(12), .DELAY_B_P(4)) u_x (
        .clk_i(clk), .rstn_i(rstn), .valid_i(vin), .ready_o(rdy_x), .data_i(din),
        .valid_o(vld_x), .ready_i(rin), .data_a_o(xa), .data_b_o(xb)
    );

    dual_tap_ram_delay #(.WIDTH_P(W), .DELAY_P(D), .DELAY_A_P(0), .DELAY_B_P(D)) u_y (
        .clk_i(clk), .rstn_i(rstn), .valid_i(vin), .ready_o(rdy_y), .data_i(din),
        .valid_o(vld_y), .ready_i(rin), .data_a_o(ya), .data_b_o(yb)
    );

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W-1:0] acc[$];
    bit           exp_v;
    logic [W-1:0] exp_d[4];
    bit           known[4];
    int           dly[4] = '{12, 4, 0, 12};
    string        tap_name[4] = '{"x_a", "x_b", "y_a", "y_b"};
    logic [W-1:0] obs[4];

    always_comb begin
        obs[0] = xa;
        obs[1] = xb;
        obs[2] = ya;
        obs[3] = yb;
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        acc.delete();
        exp_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = '0;
            known[i] = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " valid_x"}, 32'(vld_x), 32'(exp_v));
        check({tag, " valid_y"}, 32'(vld_y), 32'(exp_v));
        for (int i = 0; i < 4; i++) begin
            if (known[i]) check({tag, " ", tap_name[i]}, 32'(obs[i]), 32'(exp_d[i]));
        end
    endtask

    // Called at a negedge; returns whether the model accepted the offered sample.
    task automatic step(input string tag, input bit v, input logic [W-1:0] d, input bit r,
                        output bit accepted);
        bit rdy_e;
        int n;
        vin = v;
        din = d;
        rin = r;
        #1;
        rdy_e = !exp_v || r;
        check({tag, " ready_x"}, 32'(rdy_x), 32'(rdy_e));
        check({tag, " ready_y"}, 32'(rdy_y), 32'(rdy_e));
        accepted = v && rdy_e;
        @(posedge clk);
        if (accepted) begin
            acc.push_back(d);
            n = acc.size() - 1;
            for (int i = 0; i < 4; i++) begin
                if (n >= dly[i]) begin
                    exp_d[i] = acc[n - dly[i]];
                    known[i] = 1'b1;
                end else begin
                    known[i] = 1'b0;
                end
            end
        end
        if (rdy_e) exp_v = v;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic stream(input string tag, input int count, input int bp_at);
        int nv = 0;
        int bp = 0;
        int cyc = 0;
        bit r;
        bit a;
        while (nv < count && cyc < 400) begin
            r = !(nv == bp_at && bp < 5);
            step(tag, 1'b1, W'(nv), r, a);
            if (!r) begin
                bp++;
                check({tag, " bp_no_accept"}, 32'(a), 32'(0));
            end
            if (a) nv++;
            cyc++;
        end
        check({tag, " count"}, 32'(nv), 32'(count));
    endtask

    initial begin
        bit a;
        int cnt;
        int cyc;

        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check("reset ready_x", 32'(rdy_x), 32'(1));
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 8'hA5, i[0], a);

        // Back-to-back 0..39 with a 5-cycle stall while sample 20 is pending.
        stream("stream", 40, 20);

        cnt = 0;
        cyc = 0;
        while (cnt < 200 && cyc < 2000) begin
            step("rand", ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 3) != 0), a);
            if (a) cnt++;
            cyc++;
        end
        check("rand count", 32'(cnt), 32'(200));

        // Restart from a clean reset, then stop mid-stream after 20 samples and reset again.
        @(negedge clk);
        rstn = 1'b0;
        vin  = 1'b0;
        #1;
        model_reset();
        check_outputs("reset2");
        @(negedge clk);
        rstn = 1'b1;
        stream("pre", 20, -1);

        @(negedge clk);
        rstn = 1'b0;
        vin  = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        check("midreset ready_y", 32'(rdy_y), 32'(1));
        @(negedge clk);
        rstn = 1'b1;
        stream("restart", 30, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
